// File: rtl/telemetry_pkg.sv
// Shared constants and FSM state type for the telemetry UART transmitter.
package telemetry_pkg;

  localparam logic [7:0]  SYNC_BYTE     = 8'hA5;
  localparam int unsigned BITS_PER_BYTE = 10;

  typedef enum logic [1:0] {
    StIdle,
    StSync,
    StData,
    StCsum
  } pkt_state_e;

endpackage

// File: rtl/telemetry_uart_tx_if.sv
// Sample intake handshake between the converter datapath and the telemetry transmitter.
interface telemetry_uart_tx_if;

  logic [7:0] sample_in;
  logic       sample_valid;
  logic       sample_ready;

  modport master (
    output sample_in,
    output sample_valid,
    input  sample_ready
  );

  modport slave (
    input  sample_in,
    input  sample_valid,
    output sample_ready
  );

endinterface

// File: rtl/uart_byte_tx.sv
// 8N1 byte serialiser; byte_done is asserted in the last cycle of the stop bit so a
// load on that same edge produces back-to-back bytes.
module uart_byte_tx
  import telemetry_pkg::*;
#(
  parameter int unsigned CLK_DIV = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       load,
  input  logic [7:0] tx_byte,
  output logic       tx,
  output logic       byte_done
);

  localparam int unsigned DivW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int unsigned IdxW = $clog2(BITS_PER_BYTE);

  logic [DivW-1:0]          div_q;
  logic [IdxW-1:0]          idx_q;
  logic [BITS_PER_BYTE-1:0] frame_q;
  logic                     active_q;
  logic                     tx_q;
  logic                     bit_end;

  assign bit_end   = active_q && (div_q == DivW'(CLK_DIV - 1));
  assign byte_done = bit_end && (idx_q == IdxW'(BITS_PER_BYTE - 1));
  assign tx        = tx_q;

  // frame_q[0] always holds the bit currently on the line.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      active_q <= 1'b0;
      div_q    <= '0;
      idx_q    <= '0;
      frame_q  <= '1;
      tx_q     <= 1'b1;
    end else if (load) begin
      active_q <= 1'b1;
      div_q    <= '0;
      idx_q    <= '0;
      frame_q  <= {1'b1, tx_byte, 1'b0};
      tx_q     <= 1'b0;
    end else if (active_q) begin
      if (bit_end) begin
        div_q <= '0;
        if (byte_done) begin
          active_q <= 1'b0;
          tx_q     <= 1'b1;
        end else begin
          idx_q   <= idx_q + 1'b1;
          frame_q <= {1'b1, frame_q[BITS_PER_BYTE-1:1]};
          tx_q    <= frame_q[1];
        end
      end else begin
        div_q <= div_q + 1'b1;
      end
    end
  end

endmodule

// File: rtl/telemetry_uart_tx.sv
// Telemetry transmitter: sample FIFO, checksum accumulator and packet FSM that sends
// sync byte, FRAME_LEN payload bytes and a mod-256 payload checksum.
module telemetry_uart_tx
  import telemetry_pkg::*;
#(
  parameter int unsigned CLK_DIV    = 16,
  parameter int unsigned FRAME_LEN  = 4,
  parameter int unsigned FIFO_DEPTH = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                ena,
  telemetry_uart_tx_if.slave  smp,
  output logic                tx,
  output logic                busy,
  output logic                pkt_done
);

  localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
  localparam int unsigned CntW = PtrW + 1;
  localparam int unsigned LenW = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;

  logic [7:0]      mem_q [FIFO_DEPTH];
  logic [PtrW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0] count_q;
  logic            full, push, pop;
  logic [7:0]      head;

  pkt_state_e      state_q;
  logic [LenW-1:0] data_cnt_q;
  logic [7:0]      csum_q;
  logic            busy_q, pkt_done_q;

  logic            start, last_payload, load, byte_done;
  logic [7:0]      load_byte;

  assign full             = (count_q == CntW'(FIFO_DEPTH));
  assign smp.sample_ready = !full;
  assign push             = smp.sample_valid && !full;
  assign head             = mem_q[rd_ptr_q];

  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= smp.sample_in;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      unique case ({push, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  assign start        = ena && (count_q >= CntW'(FRAME_LEN));
  assign last_payload = (data_cnt_q == LenW'(FRAME_LEN - 1));

  // Each byte is loaded (and payload popped) on the edge its start bit begins.
  always_comb begin
    load      = 1'b0;
    load_byte = SYNC_BYTE;
    pop       = 1'b0;
    unique case (state_q)
      StIdle: load = start;
      StSync: begin
        load      = byte_done;
        load_byte = head;
        pop       = byte_done;
      end
      StData: begin
        load      = byte_done;
        load_byte = last_payload ? csum_q : head;
        pop       = byte_done && !last_payload;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      data_cnt_q <= '0;
      csum_q     <= '0;
      busy_q     <= 1'b0;
      pkt_done_q <= 1'b0;
    end else begin
      pkt_done_q <= 1'b0;
      if (pop) csum_q <= csum_q + head;
      unique case (state_q)
        StIdle: if (start) begin
          state_q    <= StSync;
          busy_q     <= 1'b1;
          csum_q     <= '0;
          data_cnt_q <= '0;
        end
        StSync: if (byte_done) state_q <= StData;
        StData: if (byte_done) begin
          if (last_payload) state_q <= StCsum;
          else              data_cnt_q <= data_cnt_q + 1'b1;
        end
        StCsum: if (byte_done) begin
          state_q    <= StIdle;
          busy_q     <= 1'b0;
          pkt_done_q <= 1'b1;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign busy     = busy_q;
  assign pkt_done = pkt_done_q;

  uart_byte_tx #(
    .CLK_DIV (CLK_DIV)
  ) u_byte_tx (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (load),
    .tx_byte   (load_byte),
    .tx        (tx),
    .byte_done (byte_done)
  );

endmodule

// File: tb/tb_telemetry_uart_tx.sv
// Directed bench for telemetry_uart_tx: decodes the serial line and scores packets
// against a queue of accepted samples.
module tb_telemetry_uart_tx;
  import telemetry_pkg::*;

  localparam int CLK_DIV    = 4;
  localparam int FRAME_LEN  = 2;
  localparam int FIFO_DEPTH = 8;
  localparam int PKT_CYC    = (FRAME_LEN + 2) * 10 * CLK_DIV;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic ena = 1'b0;
  logic tx, busy, pkt_done;

  telemetry_uart_tx_if smp_if ();

  telemetry_uart_tx #(
    .CLK_DIV    (CLK_DIV),
    .FRAME_LEN  (FRAME_LEN),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .ena      (ena),
    .smp      (smp_if.slave),
    .tx       (tx),
    .busy     (busy),
    .pkt_done (pkt_done)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_err    = 0;
  int cyc      = 0;
  int pd_count = 0;
  int last_acc = 0;
  logic [7:0] in_q[$];
  logic [7:0] exp_q[$];
  bit acc_flag = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) if (pkt_done === 1'b1) pd_count <= pd_count + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Sample driver: acceptance is decided at the negedge before the accepting posedge.
  initial begin
    smp_if.sample_in    = 8'h00;
    smp_if.sample_valid = 1'b0;
    forever begin
      @(negedge clk);
      if (smp_if.sample_valid && acc_flag) begin
        void'(in_q.pop_front());
        smp_if.sample_valid = 1'b0;
      end
      acc_flag = 1'b0;
      if (!smp_if.sample_valid && in_q.size() > 0) begin
        smp_if.sample_in    = in_q[0];
        smp_if.sample_valid = 1'b1;
      end
      if (smp_if.sample_valid && smp_if.sample_ready && rst_n) begin
        acc_flag = 1'b1;
        exp_q.push_back(smp_if.sample_in);
        last_acc = cyc + 1;
      end
    end
  end

  // Entered at the first negedge of a start bit; leaves 10*CLK_DIV negedges later.
  task automatic rx_byte(output logic [7:0] b);
    repeat (CLK_DIV / 2) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      repeat (CLK_DIV) @(negedge clk);
      b[i] = tx;
    end
    repeat (CLK_DIV) @(negedge clk);
    check("stop_bit", {31'd0, tx}, 32'd1);
    repeat (CLK_DIV - CLK_DIV / 2) @(negedge clk);
  endtask

  task automatic rx_packet(input bit chk_lat, input bit drop_ena);
    int waited = 0;
    int start_cyc;
    logic [7:0] b, exp_b, sum;
    while (tx !== 1'b0 && waited < 3000) begin
      @(negedge clk);
      waited++;
    end
    check("start_seen", {31'd0, tx}, 32'd0);
    if (tx !== 1'b0) return;
    start_cyc = cyc;
    if (drop_ena) ena = 1'b0;
    check("busy_at_start", {31'd0, busy}, 32'd1);
    if (chk_lat) check("start_latency", start_cyc - last_acc, 32'd1);
    rx_byte(b);
    check("sync_byte", {24'd0, b}, {24'd0, SYNC_BYTE});
    sum = 8'h00;
    for (int i = 0; i < FRAME_LEN; i++) begin
      rx_byte(b);
      exp_b = 8'h00;
      if (exp_q.size() > 0) exp_b = exp_q.pop_front();
      sum = sum + exp_b;
      check("payload", {24'd0, b}, {24'd0, exp_b});
    end
    rx_byte(b);
    check("checksum", {24'd0, b}, {24'd0, sum});
    check("pkt_len", cyc - start_cyc, PKT_CYC);
    check("pkt_done_pulse", {31'd0, pkt_done}, 32'd1);
    check("busy_after", {31'd0, busy}, 32'd0);
    check("tx_gap", {31'd0, tx}, 32'd1);
    @(negedge clk);
    check("pkt_done_single", {31'd0, pkt_done}, 32'd0);
  endtask

  initial begin
    int lows;
    int waited;
    int pd_before;

    // Reset values
    repeat (3) @(negedge clk);
    check("rst_tx", {31'd0, tx}, 32'd1);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_pkt_done", {31'd0, pkt_done}, 32'd0);
    check("rst_ready", {31'd0, smp_if.sample_ready}, 32'd1);
    rst_n = 1'b1;
    lows = 0;
    repeat (100) begin
      @(negedge clk);
      if (tx !== 1'b1) lows++;
    end
    check("idle_tx_high", lows, 32'd0);

    // Basic packet: A5 32 5A 8C
    ena = 1'b1;
    in_q.push_back(8'h32);
    in_q.push_back(8'h5A);
    rx_packet(1'b1, 1'b0);

    // Checksum wrap: FF + 02 = 01
    in_q.push_back(8'hFF);
    in_q.push_back(8'h02);
    rx_packet(1'b1, 1'b0);

    // FIFO full while disabled
    ena = 1'b0;
    for (int i = 1; i <= 9; i++) in_q.push_back(8'(i));
    repeat (20) @(negedge clk);
    check("full_ready_low", {31'd0, smp_if.sample_ready}, 32'd0);
    check("full_accepted", exp_q.size(), 32'd8);
    check("ninth_held", in_q.size(), 32'd1);
    check("no_start_disabled", {31'd0, busy}, 32'd0);
    ena = 1'b1;
    repeat (4) rx_packet(1'b0, 1'b0);
    check("ninth_pending", exp_q.size(), 32'd1);

    // Reset during the first payload byte
    in_q.push_back(8'h11);
    waited = 0;
    while (busy !== 1'b1 && waited < 200) begin
      @(negedge clk);
      waited++;
    end
    check("busy_before_rst", {31'd0, busy}, 32'd1);
    repeat (10 * CLK_DIV + 6) @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    check("midrst_tx", {31'd0, tx}, 32'd1);
    check("midrst_busy", {31'd0, busy}, 32'd0);
    check("midrst_pkt_done", {31'd0, pkt_done}, 32'd0);
    check("midrst_ready", {31'd0, smp_if.sample_ready}, 32'd1);
    in_q.delete();
    exp_q.delete();
    repeat (4) @(negedge clk);
    rst_n = 1'b1;
    pd_before = pd_count;
    in_q.push_back(8'h10);
    lows = 0;
    repeat (60) begin
      @(negedge clk);
      if (tx !== 1'b1 || busy !== 1'b0) lows++;
    end
    check("fifo_flushed", lows, 32'd0);
    check("no_pkt_done_after_rst", pd_count - pd_before, 32'd0);
    in_q.push_back(8'h20);
    rx_packet(1'b1, 1'b0);

    // ena drops during the sync byte with two frames queued
    for (int i = 0; i < 4; i++) in_q.push_back(8'(8'h40 + i));
    rx_packet(1'b0, 1'b1);
    lows = 0;
    repeat (100) begin
      @(negedge clk);
      if (tx !== 1'b1 || busy !== 1'b0) lows++;
    end
    check("held_off_while_disabled", lows, 32'd0);
    ena = 1'b1;
    rx_packet(1'b0, 1'b0);
    check("scoreboard_drained", exp_q.size(), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
